player_motion_ctrl: RTL



---
 rtl/player_motion_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/player_motion_ctrl.sv
// rtl/player_motion_ctrl.sv - per-player frame-gated jump/gravity motion sequencer
// Optional jump buffer in FALL enabled by defining PLAYER_JUMP_BUFFER_EN.
module player_motion_ctrl #(
    parameter logic [7:0] UP_CODE    = 8'h52,
    parameter logic [7:0] LEFT_CODE  = 8'h50,
    parameter logic [7:0] RIGHT_CODE = 8'h4f,
    parameter int         X_STEP     = 2,
    parameter int         JUMP_V0    = 8,
    parameter int         GRAVITY    = 1,
    parameter int         MAX_FALL   = 8,
    parameter int         BUF_FRAMES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [15:0] keycode,
    input  logic        on_ground,
    input  logic        head_blocked,
    output logic [9:0]  x_vel,
    output logic [9:0]  y_vel,
    output logic [1:0]  state,
    output logic        jump_start
);

    typedef enum logic [1:0] {
        GROUND  = 2'b00,
        RISE    = 2'b01,
        FALL    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic signed [9:0] X_S    = 10'(X_STEP);
    localparam logic signed [9:0] JV_S   = 10'(JUMP_V0);
    localparam logic signed [9:0] GRAV_S = 10'(GRAVITY);
    localparam logic signed [9:0] MAXF_S = 10'(MAX_FALL);
    localparam logic signed [9:0] ZERO_S = 10'sd0;

    state_t            cur_state, nxt_state;
    logic signed [9:0] y_q, y_d, x_q, x_d, nv;
    logic              fs1, fs2, fs3, tick;
    logic              up, left, right, up_prev, jump_edge, launch;

    // fs3 remembers the synced level so a held frame_clk yields one tick
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fs1 <= 1'b0;
            fs2 <= 1'b0;
            fs3 <= 1'b0;
        end else begin
            fs1 <= frame_clk;
            fs2 <= fs1;
            fs3 <= fs2;
        end
    end

    assign tick      = fs2 & ~fs3;
    assign up        = (keycode[15:8] == UP_CODE);
    assign left      = (keycode[7:0] == LEFT_CODE);
    assign right     = (keycode[7:0] == RIGHT_CODE);
    assign jump_edge = up & ~up_prev;
    assign nv        = y_q + GRAV_S;

`ifdef PLAYER_JUMP_BUFFER_EN
    logic [7:0] buf_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            buf_cnt <= 8'd0;
        end else if (tick) begin
            if (launch)
                buf_cnt <= 8'd0;
            else if (cur_state == FALL && jump_edge)
                buf_cnt <= 8'(BUF_FRAMES);
            else if (buf_cnt != 8'd0)
                buf_cnt <= buf_cnt - 8'd1;
        end
    end
`endif

    always_comb begin
        nxt_state = cur_state;
        y_d       = y_q;
        launch    = 1'b0;
        if (left)
            x_d = -X_S;
        else if (right)
            x_d = X_S;
        else
            x_d = ZERO_S;

        case (cur_state)
            GROUND: begin
                if (jump_edge && on_ground) begin
                    nxt_state = RISE;
                    y_d       = -JV_S;
                    launch    = 1'b1;
                end else if (!on_ground) begin
                    nxt_state = FALL;
                    y_d       = GRAV_S;
                end else begin
                    y_d = ZERO_S;
                end
            end
            RISE: begin
                // a ceiling hit wins even if the sprite also reports ground
                if (head_blocked) begin
                    nxt_state = FALL;
                    y_d       = ZERO_S;
                end else begin
                    y_d = nv;
                    if (nv >= ZERO_S)
                        nxt_state = FALL;
                end
            end
            FALL: begin
                if (on_ground) begin
                    nxt_state = GROUND;
                    y_d       = ZERO_S;
`ifdef PLAYER_JUMP_BUFFER_EN
                    if (buf_cnt != 8'd0) begin
                        nxt_state = RISE;
                        y_d       = -JV_S;
                        launch    = 1'b1;
                    end
`endif
                end else begin
                    y_d = (nv > MAXF_S) ? MAXF_S : nv;
                end
            end
            default: begin
                nxt_state = FALL;
                y_d       = ZERO_S;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cur_state  <= GROUND;
            y_q        <= ZERO_S;
            x_q        <= ZERO_S;
            jump_start <= 1'b0;
            up_prev    <= 1'b1;
        end else begin
            jump_start <= tick & launch;
            if (tick) begin
                cur_state <= nxt_state;
                y_q       <= y_d;
                x_q       <= x_d;
                up_prev   <= up;
            end
        end
    end

    assign state = cur_state;
    assign x_vel = x_q;
    assign y_vel = y_q;

endmodule
